// File: rtl/rvvi_depacketizer.sv
// RVVI trace depacketizer: rebuilds one RVVI trace vector per Ethernet frame
// received as 32-bit AXI-stream beats, dropping and counting malformed frames.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   RvviAxiR*           RX stream (data, tkeep, valid, last) and beat accept
//   rvvi, valid         reassembled trace vector and its record-valid flag
//   RvviReady           downstream consumes the record when valid & RvviReady
//   SeqTag              tag of the frame held on rvvi
//   GoodFrames          saturating count of accepted frames
//   BadFrames           saturating count of dropped frames
//   FrameError          one-cycle pulse per dropped frame
module rvvi_depacketizer #(
    parameter int          XLEN          = 64,
    parameter int          MAX_CSRS      = 5,
    parameter int          RVVI_W        = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
    parameter int          PAYLOAD_WORDS = (RVVI_W + 31) / 32,
    parameter logic [47:0] DST_MAC       = 48'h4502_1111_6843,
    parameter logic [15:0] ETHER_TYPE    = 16'h005c
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       RvviAxiRdata,
    input  logic [3:0]        RvviAxiRstrb,
    input  logic              RvviAxiRvalid,
    input  logic              RvviAxiRlast,
    output logic              RvviAxiRready,
    output logic [RVVI_W-1:0] rvvi,
    output logic              valid,
    input  logic              RvviReady,
    output logic [15:0]       SeqTag,
    output logic [15:0]       GoodFrames,
    output logic [15:0]       BadFrames,
    output logic              FrameError
);

    localparam int         ASM_W    = PAYLOAD_WORDS * 32;
    localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_WORDS - 1);

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_PAY  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [15:0]       tag_q, tag_d;
    logic [RVVI_W-1:0] rvvi_q, rvvi_d;
    logic [15:0]       seq_q, seq_d;
    logic              valid_q, valid_d;
    logic [15:0]       good_q, good_d;
    logic [15:0]       bad_q, bad_d;
    logic              ferr_q, ferr_d;

    logic final_beat;
    logic beat;
    logic strb_bad;
    logic err;
    logic done;

    // The final payload beat is held off while an unconsumed record is
    // still on the output, so a completed frame never overwrites it.
    assign final_beat    = (state_q == S_PAY) && (idx_q == LAST_IDX);
    assign RvviAxiRready = !(final_beat && valid_q && !RvviReady);
    assign beat          = RvviAxiRvalid && RvviAxiRready;
    assign strb_bad      = (RvviAxiRstrb != 4'hF);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        tag_d   = tag_q;
        rvvi_d  = rvvi_q;
        seq_d   = seq_q;
        valid_d = valid_q;
        good_d  = good_q;
        bad_d   = bad_q;
        ferr_d  = 1'b0;
        err     = 1'b0;
        done    = 1'b0;

        if (valid_q && RvviReady) begin
            valid_d = 1'b0;
        end

        if (beat) begin
            case (state_q)
                S_HDR: begin
                    err = strb_bad || RvviAxiRlast;
                    case (idx_q)
                        5'd0: if (RvviAxiRdata != DST_MAC[31:0]) err = 1'b1;
                        5'd1: if (RvviAxiRdata[15:0] != DST_MAC[47:32]) err = 1'b1;
                        5'd3: if (RvviAxiRdata[15:0] != ETHER_TYPE) err = 1'b1;
                        default: ;
                    endcase
                    if (!err) begin
                        if (idx_q == 5'd3) begin
                            state_d = S_PAY;
                            idx_d   = 5'd0;
                            tag_d   = RvviAxiRdata[31:16];
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                S_PAY: begin
                    asm_d[{idx_q, 5'b0} +: 32] = RvviAxiRdata;
                    err   = strb_bad || (RvviAxiRlast != final_beat);
                    done  = !err && final_beat;
                    idx_d = idx_q + 5'd1;
                    if (done) begin
                        state_d = S_HDR;
                        idx_d   = 5'd0;
                    end
                end
                S_DROP: begin
                    if (RvviAxiRlast) begin
                        state_d = S_HDR;
                        idx_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = S_HDR;
                    idx_d   = 5'd0;
                end
            endcase

            // A bad beat that also ends the frame needs no drain phase.
            if (err) begin
                state_d = RvviAxiRlast ? S_HDR : S_DROP;
                idx_d   = 5'd0;
                ferr_d  = 1'b1;
                bad_d   = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
            end

            if (done) begin
                rvvi_d  = asm_d[RVVI_W-1:0];
                seq_d   = tag_q;
                valid_d = 1'b1;
                good_d  = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HDR;
            idx_q   <= 5'd0;
            asm_q   <= '0;
            tag_q   <= 16'd0;
            rvvi_q  <= '0;
            seq_q   <= 16'd0;
            valid_q <= 1'b0;
            good_q  <= 16'd0;
            bad_q   <= 16'd0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            tag_q   <= tag_d;
            rvvi_q  <= rvvi_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rvvi       = rvvi_q;
    assign valid      = valid_q;
    assign SeqTag     = seq_q;
    assign GoodFrames = good_q;
    assign BadFrames  = bad_q;
    assign FrameError = ferr_q;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed testbench for rvvi_depacketizer (XLEN=64, MAX_CSRS=5).
// Frames are 29 beats: 4 header words plus 25 payload words.
module tb_rvvi_depacketizer;

    localparam int W = 792;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   RvviAxiRdata = 32'd0;
    logic [3:0]    RvviAxiRstrb = 4'hF;
    logic          RvviAxiRvalid = 1'b0;
    logic          RvviAxiRlast = 1'b0;
    logic          RvviAxiRready;
    logic [W-1:0]  rvvi;
    logic          valid;
    logic          RvviReady = 1'b1;
    logic [15:0]   SeqTag;
    logic [15:0]   GoodFrames;
    logic [15:0]   BadFrames;
    logic          FrameError;

    int n_checks = 0;
    int n_err    = 0;
    int fe_cnt   = 0;
    int vld_cnt  = 0;
    int stall_cnt = 0;

    localparam logic [31:0] DST_LO = 32'h1111_6843;

    rvvi_depacketizer dut (
        .clk           (clk),
        .reset         (reset),
        .RvviAxiRdata  (RvviAxiRdata),
        .RvviAxiRstrb  (RvviAxiRstrb),
        .RvviAxiRvalid (RvviAxiRvalid),
        .RvviAxiRlast  (RvviAxiRlast),
        .RvviAxiRready (RvviAxiRready),
        .rvvi          (rvvi),
        .valid         (valid),
        .RvviReady     (RvviReady),
        .SeqTag        (SeqTag),
        .GoodFrames    (GoodFrames),
        .BadFrames     (BadFrames),
        .FrameError    (FrameError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (FrameError) fe_cnt++;
        if (valid) vld_cnt++;
        if (RvviAxiRvalid && !RvviAxiRready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fword(input int i, input logic [15:0] tag,
                                          input logic [31:0] base,
                                          input logic [31:0] w0);
        case (i)
            0:       return w0;
            1:       return {16'h1234, 16'h4502};
            2:       return 32'h5678_9ABC;
            3:       return {tag, 16'h005c};
            default: return base + 32'(i - 4);
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        RvviAxiRdata  = d;
        RvviAxiRstrb  = 4'hF;
        RvviAxiRlast  = l;
        RvviAxiRvalid = 1'b1;
        #1;
        while (!RvviAxiRready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("beat_wait", 64'(n), 64'd0);
        @(posedge clk);
        @(negedge clk);
        RvviAxiRvalid = 1'b0;
        RvviAxiRlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] tag, input logic [31:0] base,
                              input logic [31:0] w0, input int nbeats,
                              input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(fword(i, tag, base, w0), i == last_at);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        RvviAxiRvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fe_cnt = 0;
        vld_cnt = 0;
        stall_cnt = 0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_good", 64'(GoodFrames), 64'd0);
        check("rst_bad", 64'(BadFrames), 64'd0);
        check("rst_tag", 64'(SeqTag), 64'd0);
        check("rst_rvvi_lo", rvvi[63:0], 64'd0);
        check("rst_ready", 64'(RvviAxiRready), 64'd1);
        check("rst_ferr", 64'(FrameError), 64'd0);

        // 1: one good frame
        RvviReady = 1'b1;
        @(negedge clk);
        send_frame(16'h0007, 32'hA500_0000, DST_LO, 29, 28);
        check("t1_valid", 64'(valid), 64'd1);
        check("t1_rvvi_lo", 64'(rvvi[31:0]), 64'hA500_0000);
        check("t1_rvvi_hi", 64'(rvvi[791:768]), 64'h000018);
        check("t1_rvvi_w12", 64'(rvvi[415:384]), 64'hA500_000C);
        check("t1_tag", 64'(SeqTag), 64'd7);
        check("t1_good", 64'(GoodFrames), 64'd1);
        settle();
        check("t1_vld_cycles", 64'(vld_cnt), 64'd1);
        check("t1_valid_clr", 64'(valid), 64'd0);
        check("t1_bad", 64'(BadFrames), 64'd0);

        // 2: bad destination MAC, then a good frame
        do_reset();
        send_frame(16'h0002, 32'hD000_0000, 32'h1111_6844, 29, 28);
        settle();
        check("t2_bad", 64'(BadFrames), 64'd1);
        check("t2_fe", 64'(fe_cnt), 64'd1);
        check("t2_novalid", 64'(vld_cnt), 64'd0);
        check("t2_nostall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        send_frame(16'h0003, 32'hD100_0000, DST_LO, 29, 28);
        settle();
        check("t2_good", 64'(GoodFrames), 64'd1);
        check("t2_vld", 64'(vld_cnt), 64'd1);
        check("t2_tag", 64'(SeqTag), 64'd3);

        // 3: early last, recovery, then late last
        do_reset();
        send_frame(16'h0004, 32'hE000_0000, DST_LO, 15, 14);
        settle();
        check("t3_bad1", 64'(BadFrames), 64'd1);
        check("t3_fe1", 64'(fe_cnt), 64'd1);
        @(negedge clk);
        send_frame(16'h0005, 32'hE100_0000, DST_LO, 29, 28);
        settle();
        check("t3_good", 64'(GoodFrames), 64'd1);
        @(negedge clk);
        send_frame(16'h0006, 32'hE200_0000, DST_LO, 31, 30);
        settle();
        check("t3_bad2", 64'(BadFrames), 64'd2);
        check("t3_fe2", 64'(fe_cnt), 64'd2);
        check("t3_vld", 64'(vld_cnt), 64'd1);
        check("t3_good2", 64'(GoodFrames), 64'd1);

        // 4: back-pressure with two frames back-to-back
        do_reset();
        RvviReady = 1'b0;
        send_frame(16'h0011, 32'hB000_0000, DST_LO, 29, 28);
        check("t4_valid1", 64'(valid), 64'd1);
        check("t4_tag1", 64'(SeqTag), 64'h11);
        fork
            send_frame(16'h0022, 32'hC000_0000, DST_LO, 29, 28);
            begin
                int n;
                n = 0;
                while (stall_cnt == 0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("t4_stall_seen", 64'(stall_cnt != 0), 64'd1);
                repeat (2) @(negedge clk);
                check("t4_hold_ready", 64'(RvviAxiRready), 64'd0);
                check("t4_hold_rvvi", 64'(rvvi[31:0]), 64'hB000_0000);
                check("t4_hold_tag", 64'(SeqTag), 64'h11);
                check("t4_hold_good", 64'(GoodFrames), 64'd1);
                RvviReady = 1'b1;
            end
        join
        check("t4_valid2", 64'(valid), 64'd1);
        check("t4_tag2", 64'(SeqTag), 64'h22);
        check("t4_rvvi2", 64'(rvvi[31:0]), 64'hC000_0000);
        check("t4_good2", 64'(GoodFrames), 64'd2);
        settle();
        check("t4_valid_clr", 64'(valid), 64'd0);

        // 5: reset in mid-frame, remainder dropped
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send_beat(fword(i, 16'h0009, 32'hF000_0000, DST_LO), 1'b0);
        end
        do_reset();
        for (int i = 12; i < 29; i++) begin
            send_beat(fword(i, 16'h0009, 32'hF000_0000, DST_LO), i == 28);
        end
        settle();
        check("t5_bad", 64'(BadFrames), 64'd1);
        check("t5_fe", 64'(fe_cnt), 64'd1);
        check("t5_novalid", 64'(vld_cnt), 64'd0);
        @(negedge clk);
        send_frame(16'h000A, 32'hF100_0000, DST_LO, 29, 28);
        settle();
        check("t5_good", 64'(GoodFrames), 64'd1);
        check("t5_tag", 64'(SeqTag), 64'h0A);

        // 6: GoodFrames saturation
        do_reset();
        force dut.good_q = 16'hFFFE;
        @(negedge clk);
        release dut.good_q;
        send_frame(16'h0031, 32'h1000_0000, DST_LO, 29, 28);
        check("t6_good1", 64'(GoodFrames), 64'hFFFF);
        @(negedge clk);
        send_frame(16'h0032, 32'h2000_0000, DST_LO, 29, 28);
        @(negedge clk);
        send_frame(16'h0033, 32'h3000_0000, DST_LO, 29, 28);
        settle();
        check("t6_good3", 64'(GoodFrames), 64'hFFFF);
        check("t6_vld", 64'(vld_cnt), 64'd3);
        check("t6_tag", 64'(SeqTag), 64'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
